hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
- Parametrised hazard controller for the pipelined CPU; successor to the single-cycle combinational load-use detector.
- Adds multi-cycle load-use stalls for configurable memory latency, stalls on a busy multi-cycle multiply/divide unit (MDU), and multi-cycle branch flush for deeper pipelines.
- Adds saturating stall/flush statistics counters.
- Sits between IF/ID and ID/EX; drives PC write enable, IF/ID write enable, control-bubble select and flush.

Parameters:
- REG_AW, 5, register-index width.
- LOAD_STALLS, 1, bubble cycles per load-use hazard (0 disables load-use stalling).
- FLUSH_CYCLES, 1, cycles Flush_o is held per taken branch (≥1).
- IGNORE_R0, 1, when 1 register index 0 never causes a hazard.
- CNT_W, 16, statistics counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- IF_ID_RegisterRs_i  in  REG_AW  source Rs of instruction in ID.
- IF_ID_RegisterRt_i  in  REG_AW  source Rt of instruction in ID.
- IF_ID_UsesRt_i  in  1  ID instruction reads Rt (0 for I-type ALU/load).
- ID_EX_MemRead_i  in  1  instruction in EX is a load.
- ID_EX_RegisterRt_i  in  REG_AW  load destination in EX.
- mdu_busy_i  in  1  MDU computing.
- mdu_dst_i  in  REG_AW  MDU destination register.
- Branch_i  in  1  taken branch/jump resolved this cycle.
- clr_stats_i  in  1  synchronous clear of statistics counters.
- PCWrite_o  out  1  1 = PC updates.
- IF_IDWrite_o  out  1  1 = IF/ID register updates.
- Control_o  out  1  1 = pass control signals; 0 = insert bubble.
- Flush_o  out  1  1 = flush IF/ID (wrong-path instruction).
- stall_cnt_o  out  CNT_W  total stalled cycles, saturating.
- flush_cnt_o  out  CNT_W  total taken-branch events, saturating.

Behaviour:
- match(r, x) = (r == x) && !(IGNORE_R0 && x == 0).
- lu_haz = ID_EX_MemRead_i && LOAD_STALLS != 0 && (match(IF_ID_RegisterRs_i, ID_EX_RegisterRt_i) || (IF_ID_UsesRt_i && match(IF_ID_RegisterRt_i, ID_EX_RegisterRt_i))).
- mdu_haz: same form using mdu_busy_i and mdu_dst_i.
- Stall cycle: PCWrite_o = IF_IDWrite_o = Control_o = 0. Otherwise all three are 1.
- FSM states: IDLE, LU_STALL, MDU_WAIT, FLUSH. Down-counter cnt is 8 bits.
- IDLE:
  - Branch_i → Flush_o = 1, no stall. If FLUSH_CYCLES > 1, go FLUSH with cnt = FLUSH_CYCLES-1.
  - else mdu_haz → stall, go MDU_WAIT.
  - else lu_haz → stall this cycle (combinational, same cycle as detect). If LOAD_STALLS > 1, go LU_STALL with cnt = LOAD_STALLS-1.
- LU_STALL: stall; cnt decrements; when cnt == 1, return to IDLE. Total stall = LOAD_STALLS cycles. The hazard is not re-evaluated.
- MDU_WAIT: stall while mdu_busy_i. When mdu_busy_i == 0, output is not stalled that cycle and the FSM returns to IDLE.
- FLUSH: Flush_o = 1, no stall; cnt decrements; when cnt == 1, return to IDLE.
- Priority: Branch_i overrides everything in every state.
  - Stall outputs forced to 1, Flush_o = 1.
  - FSM goes FLUSH (or IDLE if FLUSH_CYCLES == 1) with cnt reloaded.
  - A branch during FLUSH restarts the flush count.
- stall_cnt_o: +1 on every stall cycle. flush_cnt_o: +1 on each cycle Branch_i == 1.
  - Both saturate at all-ones.
  - clr_stats_i has priority over increment; the counter reads 0 next cycle.
- Reset (rst_i high, asynchronous): state IDLE, cnt 0, counters 0.
  - While rst_i is high: PCWrite_o = IF_IDWrite_o = Control_o = 1, Flush_o = 0, regardless of inputs.
  - Reset mid-stall or mid-flush abandons it immediately.
- Stall and flush outputs are combinational from state and inputs, with zero latency.

Test Plan:
- LOAD_STALLS=1: ID_EX_MemRead_i=1, EX Rt=5, ID Rs=5 for one cycle → exactly 1 cycle PCWrite_o=IF_IDWrite_o=Control_o=0; stall_cnt_o=1.
- LOAD_STALLS=3: same hazard, MemRead dropped after 1 cycle → 3 consecutive stall cycles, then PCWrite_o=1; stall_cnt_o=3.
- IGNORE_R0=1: load to Rt=0 with ID Rs=0 → no stall. Load Rt=7, ID Rt=7 with IF_ID_UsesRt_i=0 → no stall.
- mdu_busy_i=1, mdu_dst_i=9, ID Rs=9, busy held 4 cycles → 4 stall cycles; released the cycle mdu_busy_i falls.
- FLUSH_CYCLES=2: Branch_i asserted in the 2nd cycle of a 3-cycle LU_STALL → stall ends immediately, Flush_o=1 for 2 cycles, flush_cnt_o=1.
- rst_i asserted mid-MDU_WAIT → outputs 1/1/1/0 immediately, counters 0. After release with no hazard, no stall.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use and MDU stalls, multi-cycle branch flush,
// and saturating stall/flush statistics.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no hazard in progress; hazards detected combinationally
// LU_STALL | extra bubble cycles of a multi-cycle load-use stall
// MDU_WAIT | waiting for the MDU to drop busy
// FLUSH    | holding Flush_o for the remaining cycles of a taken branch
module hazard_ctrl_unit #(
    parameter int REG_AW       = 5,
    parameter int LOAD_STALLS  = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int IGNORE_R0    = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] IF_ID_RegisterRs_i,
    input  logic [REG_AW-1:0] IF_ID_RegisterRt_i,
    input  logic              IF_ID_UsesRt_i,
    input  logic              ID_EX_MemRead_i,
    input  logic [REG_AW-1:0] ID_EX_RegisterRt_i,
    input  logic              mdu_busy_i,
    input  logic [REG_AW-1:0] mdu_dst_i,
    input  logic              Branch_i,
    input  logic              clr_stats_i,
    output logic              PCWrite_o,
    output logic              IF_IDWrite_o,
    output logic              Control_o,
    output logic              Flush_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LU_STALL = 2'd1,
        MDU_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam logic [7:0] LU_RELOAD    = (LOAD_STALLS > 1)  ? 8'(LOAD_STALLS - 1)  : 8'd0;
    localparam logic [7:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? 8'(FLUSH_CYCLES - 1) : 8'd0;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    logic [7:0] cnt;
    logic       lu_haz;
    logic       mdu_haz;
    logic       stall;
    logic       flush;

    function automatic logic reg_match(input logic [REG_AW-1:0] r, input logic [REG_AW-1:0] x);
        return (r == x) && !((IGNORE_R0 != 0) && (x == '0));
    endfunction

    always_comb begin
        lu_haz = ID_EX_MemRead_i && (LOAD_STALLS != 0) &&
                 (reg_match(IF_ID_RegisterRs_i, ID_EX_RegisterRt_i) ||
                  (IF_ID_UsesRt_i && reg_match(IF_ID_RegisterRt_i, ID_EX_RegisterRt_i)));
        mdu_haz = mdu_busy_i &&
                  (reg_match(IF_ID_RegisterRs_i, mdu_dst_i) ||
                   (IF_ID_UsesRt_i && reg_match(IF_ID_RegisterRt_i, mdu_dst_i)));
    end

    // A taken branch always wins: the stalled instruction is on the wrong path anyway.
    always_comb begin
        stall = 1'b0;
        flush = 1'b0;
        if (Branch_i) begin
            flush = 1'b1;
        end else begin
            case (state)
                IDLE:     stall = mdu_haz || lu_haz;
                LU_STALL: stall = 1'b1;
                MDU_WAIT: stall = mdu_busy_i;
                FLUSH:    flush = 1'b1;
                default:  stall = 1'b0;
            endcase
        end
    end

    assign PCWrite_o    = rst_i | ~stall;
    assign IF_IDWrite_o = rst_i | ~stall;
    assign Control_o    = rst_i | ~stall;
    assign Flush_o      = ~rst_i & flush;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else if (Branch_i) begin
            if (FLUSH_CYCLES > 1) begin
                state <= FLUSH;
                cnt   <= FLUSH_RELOAD;
            end else begin
                state <= IDLE;
                cnt   <= 8'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (mdu_haz) begin
                        state <= MDU_WAIT;
                    end else if (lu_haz && (LOAD_STALLS > 1)) begin
                        state <= LU_STALL;
                        cnt   <= LU_RELOAD;
                    end
                end
                LU_STALL, FLUSH: begin
                    if (cnt <= 8'd1) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                MDU_WAIT: begin
                    if (!mdu_busy_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else if (clr_stats_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + CNT_ONE;
            end
            if (Branch_i && (flush_cnt_o != '1)) begin
                flush_cnt_o <= flush_cnt_o + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: three configurations driven with
// directed per-cycle vectors; a negedge monitor checks outputs against the queue.
module tb_hazard_ctrl_unit;

    typedef struct packed {
        logic       rst;
        logic       memread;
        logic [4:0] ex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       busy;
        logic [4:0] dst;
        logic       branch;
        logic       clr;
    } in_t;

    typedef struct {
        int          d;
        logic [3:0]  ctl;
        logic [15:0] sc;
        logic [15:0] fc;
        string       nm;
    } exp_t;

    localparam logic [3:0] G = 4'b1110;
    localparam logic [3:0] S = 4'b0000;
    localparam logic [3:0] F = 4'b1111;

    logic        clk;
    in_t         in_v  [3];
    logic        pcw   [3];
    logic        ifw   [3];
    logic        ctw   [3];
    logic        flw   [3];
    logic [15:0] sc_w  [3];
    logic [15:0] fc_w  [3];
    logic [1:0]  sc2;
    logic [1:0]  fc2;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // d0: LOAD_STALLS=1, FLUSH_CYCLES=1, IGNORE_R0=1
    hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALLS(1), .FLUSH_CYCLES(1), .IGNORE_R0(1), .CNT_W(16)) dut0 (
        .clk_i(clk), .rst_i(in_v[0].rst),
        .IF_ID_RegisterRs_i(in_v[0].rs), .IF_ID_RegisterRt_i(in_v[0].rt),
        .IF_ID_UsesRt_i(in_v[0].uses_rt), .ID_EX_MemRead_i(in_v[0].memread),
        .ID_EX_RegisterRt_i(in_v[0].ex_rt), .mdu_busy_i(in_v[0].busy),
        .mdu_dst_i(in_v[0].dst), .Branch_i(in_v[0].branch), .clr_stats_i(in_v[0].clr),
        .PCWrite_o(pcw[0]), .IF_IDWrite_o(ifw[0]), .Control_o(ctw[0]), .Flush_o(flw[0]),
        .stall_cnt_o(sc_w[0]), .flush_cnt_o(fc_w[0])
    );

    // d1: LOAD_STALLS=3, FLUSH_CYCLES=2
    hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALLS(3), .FLUSH_CYCLES(2), .IGNORE_R0(1), .CNT_W(16)) dut1 (
        .clk_i(clk), .rst_i(in_v[1].rst),
        .IF_ID_RegisterRs_i(in_v[1].rs), .IF_ID_RegisterRt_i(in_v[1].rt),
        .IF_ID_UsesRt_i(in_v[1].uses_rt), .ID_EX_MemRead_i(in_v[1].memread),
        .ID_EX_RegisterRt_i(in_v[1].ex_rt), .mdu_busy_i(in_v[1].busy),
        .mdu_dst_i(in_v[1].dst), .Branch_i(in_v[1].branch), .clr_stats_i(in_v[1].clr),
        .PCWrite_o(pcw[1]), .IF_IDWrite_o(ifw[1]), .Control_o(ctw[1]), .Flush_o(flw[1]),
        .stall_cnt_o(sc_w[1]), .flush_cnt_o(fc_w[1])
    );

    // d2: 2-bit counters for saturation, IGNORE_R0=0
    hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALLS(1), .FLUSH_CYCLES(1), .IGNORE_R0(0), .CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(in_v[2].rst),
        .IF_ID_RegisterRs_i(in_v[2].rs), .IF_ID_RegisterRt_i(in_v[2].rt),
        .IF_ID_UsesRt_i(in_v[2].uses_rt), .ID_EX_MemRead_i(in_v[2].memread),
        .ID_EX_RegisterRt_i(in_v[2].ex_rt), .mdu_busy_i(in_v[2].busy),
        .mdu_dst_i(in_v[2].dst), .Branch_i(in_v[2].branch), .clr_stats_i(in_v[2].clr),
        .PCWrite_o(pcw[2]), .IF_IDWrite_o(ifw[2]), .Control_o(ctw[2]), .Flush_o(flw[2]),
        .stall_cnt_o(sc2), .flush_cnt_o(fc2)
    );

    assign sc_w[2] = {14'd0, sc2};
    assign fc_w[2] = {14'd0, fc2};

    function automatic in_t vec(input logic r, input logic mr, input logic [4:0] ert,
                                input logic [4:0] rs, input logic [4:0] rt, input logic u,
                                input logic b, input logic [4:0] dst, input logic br,
                                input logic clr);
        in_t v;
        v.rst = r; v.memread = mr; v.ex_rt = ert; v.rs = rs; v.rt = rt;
        v.uses_rt = u; v.busy = b; v.dst = dst; v.branch = br; v.clr = clr;
        return v;
    endfunction

    task automatic step(input int d, input in_t v, input logic [3:0] c,
                        input logic [15:0] s, input logic [15:0] f, input string nm);
        exp_t e;
        in_v[d] = v;
        e.d = d; e.ctl = c; e.sc = s; e.fc = f; e.nm = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [3:0]  got;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                got = {pcw[e.d], ifw[e.d], ctw[e.d], flw[e.d]};
                n_cmp++;
                if (got !== e.ctl) begin
                    n_bad++;
                    $display("FAIL d%0d %s ctl(pc,ifid,ctrl,flush) got=%b want=%b", e.d, e.nm, got, e.ctl);
                end
                n_cmp++;
                if (sc_w[e.d] !== e.sc) begin
                    n_bad++;
                    $display("FAIL d%0d %s stall_cnt got=%0d want=%0d", e.d, e.nm, sc_w[e.d], e.sc);
                end
                n_cmp++;
                if (fc_w[e.d] !== e.fc) begin
                    n_bad++;
                    $display("FAIL d%0d %s flush_cnt got=%0d want=%0d", e.d, e.nm, fc_w[e.d], e.fc);
                end
            end
        end
    end

    initial begin : stimulus
        in_t idle;
        idle = vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            in_v[i]     = idle;
            in_v[i].rst = 1'b1;
        end
        @(posedge clk);
        #1;

        // dut0
        step(0, vec(1, 1, 5, 5, 0, 0, 0, 0, 0, 0), G, 0, 0, "reset");
        step(0, idle,                              G, 0, 0, "idle0");
        step(0, vec(0, 1, 5, 5, 0, 0, 0, 0, 0, 0), S, 0, 0, "lu1_stall");
        step(0, idle,                              G, 1, 0, "lu1_release");
        step(0, idle,                              G, 1, 0, "lu1_after");
        step(0, vec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), G, 1, 0, "r0_ignored");
        step(0, vec(0, 1, 7, 3, 7, 0, 0, 0, 0, 0), G, 1, 0, "rt_unused");
        step(0, vec(0, 1, 7, 3, 7, 1, 0, 0, 0, 0), S, 1, 0, "rt_used");
        step(0, idle,                              G, 2, 0, "rt_release");
        for (int k = 0; k < 4; k++)
            step(0, vec(0, 0, 0, 9, 0, 0, 1, 9, 0, 0), S, 16'(2 + k), 0, "mdu_busy");
        step(0, vec(0, 0, 0, 9, 0, 0, 0, 9, 0, 0), G, 6, 0, "mdu_fall");
        step(0, idle,                              G, 6, 0, "mdu_after");
        step(0, vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), F, 6, 0, "branch1");
        step(0, idle,                              G, 6, 1, "branch1_end");
        step(0, vec(0, 1, 5, 5, 0, 0, 0, 0, 1, 0), F, 6, 1, "branch_over_lu");
        step(0, idle,                              G, 6, 2, "branch_over_lu_end");
        step(0, vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), G, 6, 2, "clr");
        step(0, idle,                              G, 0, 0, "clr_done");
        step(0, vec(0, 1, 5, 5, 0, 0, 0, 0, 0, 1), S, 0, 0, "clr_vs_inc");
        step(0, idle,                              G, 0, 0, "clr_won");
        step(0, vec(0, 0, 0, 9, 0, 0, 1, 9, 0, 0), S, 0, 0, "mdu2_a");
        step(0, vec(0, 0, 0, 9, 0, 0, 1, 9, 0, 0), S, 1, 0, "mdu2_b");
        step(0, vec(1, 0, 0, 9, 0, 0, 1, 9, 0, 0), G, 0, 0, "rst_mid_mdu");
        step(0, vec(1, 0, 0, 9, 0, 0, 1, 9, 0, 0), G, 0, 0, "rst_hold");
        step(0, vec(0, 0, 0, 3, 0, 0, 1, 9, 0, 0), G, 0, 0, "post_rst_idle");
        step(0, idle,                              G, 0, 0, "post_rst_idle2");

        // dut1
        step(1, vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), G, 0, 0, "reset");
        step(1, idle,                              G, 0, 0, "idle0");
        step(1, vec(0, 1, 5, 5, 0, 0, 0, 0, 0, 0), S, 0, 0, "lu3_c1");
        step(1, idle,                              S, 1, 0, "lu3_c2");
        step(1, idle,                              S, 2, 0, "lu3_c3");
        step(1, idle,                              G, 3, 0, "lu3_release");
        step(1, idle,                              G, 3, 0, "lu3_after");
        step(1, vec(0, 1, 5, 5, 0, 0, 0, 0, 0, 0), S, 3, 0, "lu3b_c1");
        step(1, vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), F, 4, 0, "branch_in_lu");
        step(1, idle,                              F, 4, 1, "flush2_c2");
        step(1, idle,                              G, 4, 1, "flush2_end");
        step(1, vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), F, 4, 1, "br_a");
        step(1, vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), F, 4, 2, "br_in_flush");
        step(1, idle,                              F, 4, 3, "flush_restarted");
        step(1, idle,                              G, 4, 3, "flush_restart_end");

        // dut2
        step(2, vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), G, 0, 0, "reset");
        step(2, idle,                              G, 0, 0, "idle0");
        for (int k = 0; k < 4; k++)
            step(2, vec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), S, 16'(k), 0, "r0_hazard");
        step(2, vec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), S, 3, 0, "stall_sat");
        step(2, idle,                              G, 3, 0, "stall_sat_hold");
        for (int k = 0; k < 4; k++)
            step(2, vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), F, 3, 16'(k), "branch_cnt");
        step(2, vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), F, 3, 3, "flush_sat");
        step(2, idle,                              G, 3, 3, "flush_sat_hold");

        @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
